// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_if
// Purpose  : Operand / opcode / result bundle between the datapath and the ALU.
// Revision : 1.0
// ============================================================================
interface alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] OP1;
    logic [DATA_WIDTH-1:0] OP2;
    logic [OPRN_WIDTH-1:0] OPRN;
    logic [DATA_WIDTH-1:0] OUT;
    logic                  ZERO;

    modport master (
        output OP1,
        output OP2,
        output OPRN,
        input  OUT,
        input  ZERO
    );

    modport slave (
        input  OP1,
        input  OP2,
        input  OPRN,
        output OUT,
        output ZERO
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : 32-bit integer ALU with registered result and zero flag.
//            Define ALU_SIGNED_SLT_EN for a signed set-less-than.
// Revision : 1.0
// ============================================================================
module alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
) (
    input  wire logic CLK,
    input  wire logic RST,
    alu_if.slave      bus
);
    localparam logic [OPRN_WIDTH-1:0] c_OP_ADD = OPRN_WIDTH'(8'h01);
    localparam logic [OPRN_WIDTH-1:0] c_OP_SUB = OPRN_WIDTH'(8'h02);
    localparam logic [OPRN_WIDTH-1:0] c_OP_MUL = OPRN_WIDTH'(8'h03);
    localparam logic [OPRN_WIDTH-1:0] c_OP_SRL = OPRN_WIDTH'(8'h04);
    localparam logic [OPRN_WIDTH-1:0] c_OP_SLL = OPRN_WIDTH'(8'h05);
    localparam logic [OPRN_WIDTH-1:0] c_OP_AND = OPRN_WIDTH'(8'h06);
    localparam logic [OPRN_WIDTH-1:0] c_OP_OR  = OPRN_WIDTH'(8'h07);
    localparam logic [OPRN_WIDTH-1:0] c_OP_NOR = OPRN_WIDTH'(8'h08);
    localparam logic [OPRN_WIDTH-1:0] c_OP_SLT = OPRN_WIDTH'(8'h09);

    logic [DATA_WIDTH-1:0] w_out_d;
    logic                  w_zero_d;
    logic                  w_lt;
    logic [DATA_WIDTH-1:0] r_out_q;
    logic                  r_zero_q;

`ifdef ALU_SIGNED_SLT_EN
    assign w_lt = ($signed(bus.OP1) < $signed(bus.OP2));
`else
    assign w_lt = (bus.OP1 < bus.OP2);
`endif

    // Shift amount is the full OP2 word; SV shifts already yield zero for
    // amounts at or beyond the operand width.
    always_comb begin
        w_out_d = '0;
        unique case (bus.OPRN)
            c_OP_ADD: w_out_d = bus.OP1 + bus.OP2;
            c_OP_SUB: w_out_d = bus.OP1 - bus.OP2;
            c_OP_MUL: w_out_d = bus.OP1 * bus.OP2;
            c_OP_SRL: w_out_d = bus.OP1 >> bus.OP2;
            c_OP_SLL: w_out_d = bus.OP1 << bus.OP2;
            c_OP_AND: w_out_d = bus.OP1 & bus.OP2;
            c_OP_OR:  w_out_d = bus.OP1 | bus.OP2;
            c_OP_NOR: w_out_d = ~(bus.OP1 | bus.OP2);
            c_OP_SLT: w_out_d = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            default:  w_out_d = '0;
        endcase
    end

    assign w_zero_d = (w_out_d == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_q  <= '0;
            r_zero_q <= 1'b1;
        end else begin
            r_out_q  <= w_out_d;
            r_zero_q <= w_zero_d;
        end
    end

    assign bus.OUT  = r_out_q;
    assign bus.ZERO = r_zero_q;
endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Directed scoreboard bench for the registered ALU.
// Revision : 1.0
// ============================================================================
module tb_alu;
    typedef struct {
        string       tag;
        logic [31:0] out;
        logic        zero;
    } exp_t;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) bus ();

    alu #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one operation, queue its expected result, then after the next
    // edge pop and compare against the registered outputs.
    task automatic step(input logic rst_in, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic exp_zero,
                        input string tag);
        exp_t e;
        RST      = rst_in;
        bus.OPRN = op;
        bus.OP1  = a;
        bus.OP2  = b;
        sb.push_back('{tag, exp_out, exp_zero});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        checks++;
        assert (bus.OUT === e.out) else begin
            errors++;
            $error("FAIL %s OUT observed=%h expected=%h", e.tag, bus.OUT, e.out);
        end
        checks++;
        assert (bus.ZERO === e.zero) else begin
            errors++;
            $error("FAIL %s ZERO observed=%b expected=%b", e.tag, bus.ZERO, e.zero);
        end
    endtask

    initial begin
        logic exp_slt;
        checks   = 0;
        errors   = 0;
        RST      = 1'b1;
        bus.OPRN = '0;
        bus.OP1  = '0;
        bus.OP2  = '0;
        #1;

        step(1'b1, 6'h01, 32'd15, 32'd3, 32'd0, 1'b1, "reset");
        step(1'b0, 6'h01, 32'd15, 32'd3, 32'd18, 1'b0, "add_15_3");

        step(1'b0, 6'h02, 32'd15, 32'd5, 32'd10, 1'b0, "sub_15_5");
        step(1'b0, 6'h02, 32'd8, 32'd8, 32'd0, 1'b1, "sub_8_8");
        step(1'b0, 6'h02, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
        step(1'b0, 6'h03, 32'd3, 32'd5, 32'd15, 1'b0, "mul_3_5");
        step(1'b0, 6'h03, 32'd0, 32'd5, 32'd0, 1'b1, "mul_0_5");
        step(1'b0, 6'h03, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, "mul_high_drop");
        step(1'b0, 6'h01, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, "add_wrap");

        step(1'b0, 6'h04, 32'd18, 32'd3, 32'd2, 1'b0, "srl_18_3");
        step(1'b0, 6'h04, 32'd24, 32'd2, 32'd6, 1'b0, "srl_24_2");
        step(1'b0, 6'h05, 32'd5, 32'd3, 32'd40, 1'b0, "sll_5_3");
        step(1'b0, 6'h05, 32'd1, 32'd32, 32'd0, 1'b1, "sll_1_32");
        step(1'b0, 6'h04, 32'h8000_0000, 32'd31, 32'd1, 1'b0, "srl_msb_31");
        step(1'b0, 6'h04, 32'hFFFF_FFFF, 32'h0000_0100, 32'd0, 1'b1, "srl_big_amt");

        step(1'b0, 6'h06, 32'd3, 32'd5, 32'd1, 1'b0, "and_3_5");
        step(1'b0, 6'h07, 32'd3, 32'd5, 32'd7, 1'b0, "or_3_5");
        step(1'b0, 6'h08, 32'd3, 32'd5, 32'hFFFF_FFF8, 1'b0, "nor_3_5");
        step(1'b0, 6'h08, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "nor_neg");

        step(1'b0, 6'h09, 32'd3, 32'd5, 32'd1, 1'b0, "slt_3_5");
        step(1'b0, 6'h09, 32'd17, 32'd5, 32'd0, 1'b1, "slt_17_5");
`ifdef ALU_SIGNED_SLT_EN
        exp_slt = 1'b1;
`else
        exp_slt = 1'b0;
`endif
        step(1'b0, 6'h09, 32'hFFFF_FFF9, 32'd3, {31'd0, exp_slt}, ~exp_slt, "slt_neg7_3");

        step(1'b0, 6'h3F, 32'd7, 32'd9, 32'd0, 1'b1, "illegal_3f");
        step(1'b0, 6'h00, 32'd7, 32'd9, 32'd0, 1'b1, "illegal_00");
        step(1'b0, 6'h01, 32'd100, 32'd23, 32'd123, 1'b0, "b2b_add");
        step(1'b1, 6'h07, 32'd1, 32'd2, 32'd0, 1'b1, "reset_mid");
        step(1'b0, 6'h07, 32'd1, 32'd2, 32'd3, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the Da Vinci processor datapath.
- Computes one of nine arithmetic, shift, logic or compare operations on two operands, selected by an operation code.
- Result and zero flag are registered: sampled on the rising CLK edge and held until the next edge.
- Sits between the register-file read ports and the writeback/branch logic.

Parameters:
- DATA_WIDTH, 32, operand and result width (matches `DATA_WIDTH).
- OPRN_WIDTH, 6, operation-code width (matches `ALU_OPRN_WIDTH).

Ports:
- CLK   input   1            system clock; all state updates on the rising edge.
- RST   input   1            synchronous, active-high reset.
- OP1   input   DATA_WIDTH   operand 1.
- OP2   input   DATA_WIDTH   operand 2; also the shift amount for shifts.
- OPRN  input   OPRN_WIDTH   operation select.
- OUT   output  DATA_WIDTH   registered result.
- ZERO  output  1            registered flag: 1 when OUT == 0.

Behaviour:
- Single clock CLK. Reset RST is synchronous and active-high.
- Reset: on a rising CLK edge with RST=1, OUT <= 0 and ZERO <= 1. Reset overrides any operation presented in that cycle.
- Latency: OP1/OP2/OPRN sampled at rising edge N appear on OUT/ZERO after edge N. One cycle of latency; throughput of one operation per cycle.
- No handshake. A new operation is accepted every cycle; the inputs must be stable around the edge.
- Opcodes (OPRN value -> OUT):
  - 0x01 add: OP1+OP2, modulo 2^32, carry discarded.
  - 0x02 sub: OP1-OP2, modulo 2^32; borrow wraps (3-5 = 0xFFFFFFFE).
  - 0x03 mul: low 32 bits of the product; high half discarded.
  - 0x04 shift right logical: OP1 >> OP2, zero fill. The whole 32-bit OP2 is the shift amount; any amount >= 32 gives 0.
  - 0x05 shift left logical: OP1 << OP2, zero fill; any amount >= 32 gives 0.
  - 0x06 and: OP1 & OP2.
  - 0x07 or: OP1 | OP2.
  - 0x08 nor: ~(OP1 | OP2).
  - 0x09 set-less-than: OUT = 1 if OP1 < OP2, else 0; bits 31:1 always 0. Unsigned comparison by default (see Optional Feature).
  - Any other code (including 0x00): OUT = 0, ZERO = 1. Never X.
- ZERO is computed from the same next-OUT value and registered in the same edge as OUT, so the pair is always consistent.
- Operands are treated as raw bit vectors. No overflow or exception signalling.
- Changing OPRN or the operands between edges has no effect on the outputs until the next edge.

Optional Feature:
- Macro: ALU_SIGNED_SLT_EN.
- Defined: opcode 0x09 compares OP1 and OP2 as two's-complement signed values (-7 < 3 gives 1).
- Not defined: opcode 0x09 compares unsigned (0xFFFFFFF9 < 3 gives 0).
- All other opcodes are identical in both builds.

Test Plan:
- RST=1 for one edge with OPRN=0x01, OP1=15, OP2=3 -> OUT=0, ZERO=1. Release RST, next edge -> OUT=18, ZERO=0.
- Arithmetic, one edge each:
  - 15-5 -> 10, ZERO=0.
  - 8-8 -> 0, ZERO=1.
  - 3*5 -> 15.
  - 0*5 -> 0, ZERO=1.
  - 0xFFFFFFFF+1 -> 0, ZERO=1.
- Shifts:
  - 18>>3 -> 2.
  - 24>>2 -> 6.
  - 5<<3 -> 40.
  - 1<<32 -> 0, ZERO=1.
  - 0x80000000>>31 -> 1.
- Logic:
  - 3&5 -> 1.
  - 3|5 -> 7.
  - 3 nor 5 -> 0xFFFFFFF8.
  - -3 nor -7 (0xFFFFFFFD, 0xFFFFFFF9) -> 0x00000002.
- Compare:
  - 3<5 -> 1, ZERO=0.
  - 17<5 -> 0, ZERO=1.
  - OP1=0xFFFFFFF9, OP2=3 -> 0 without ALU_SIGNED_SLT_EN, 1 with it.
- Illegal opcode 0x3F with OP1=7, OP2=9 -> OUT=0, ZERO=1. Back-to-back ops on consecutive edges each produce their result exactly one edge later.
